mem_clock_monitor: RTL

//  Consumer side of the divided memory clock. Samples mclock in the physical_clock domain
//  and emits one-cycle rise/fall strobes for memory-side logic. Measures each mclock half-period
//  and checks it against the rate expected from clock_eff. Reports locked/lost status to the core.

---
 rtl/mem_clock_monitor.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mem_clock_monitor.sv
// Memory-clock consumer: synchronises mclock_in, emits edge ticks, measures half-periods, tracks lock.
// Latency: ticks/half_period land SYNC_STAGES cycles after the sampling edge; no backpressure (free-running).
module mem_clock_monitor #(
  parameter int MCLOCK_SIZE = 8,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4,
  parameter int TOLERANCE   = 1
) (
  input  logic        physical_clock,
  input  logic        reset,
  input  logic [31:0] clock_eff,
  input  logic        mclock_in,
  output logic        rise_tick,
  output logic        fall_tick,
  output logic [31:0] half_period,
  output logic        locked,
  output logic        lost
);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKING  = 2'd1,
    ST_LOCKED   = 2'd2,
    ST_LOST     = 2'd3
  } state_t;

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam logic signed [33:0] TOL_S = 34'(TOLERANCE);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   prev_q;
  logic                   mclk_edge;
  logic [31:0]            cnt;
  logic [32:0]            exp_hp;
  logic signed [33:0]     diff;
  logic                   match;
  logic                   timeout;

  state_t                 state_q;
  state_t                 state_nxt;
  logic [GW-1:0]          good_q;
  logic [GW-1:0]          good_nxt;
  logic                   locked_nxt;
  logic                   lost_nxt;

  assign s         = sync_q[SYNC_STAGES-1];
  assign mclk_edge = s ^ prev_q;

  always_ff @(posedge physical_clock or posedge reset) begin
    if (reset) begin
      sync_q    <= '0;
      prev_q    <= 1'b0;
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], mclock_in};
      prev_q    <= s;
      rise_tick <= mclk_edge & s;
      fall_tick <= mclk_edge & ~s;
    end
  end

  // cnt holds the cycles elapsed since the last edge, so it equals the half-period on the edge cycle
  always_ff @(posedge physical_clock or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      half_period <= '0;
    end else if (mclk_edge) begin
      half_period <= cnt;
      cnt         <= 32'd1;
    end else if (cnt != 32'hFFFF_FFFF) begin
      cnt <= cnt + 32'd1;
    end
  end

  // 33/34-bit math keeps E, |cnt-E| and 2*E free of wrap for any clock_eff
  always_comb begin
    exp_hp  = ({1'b0, clock_eff} / 33'(2 * MCLOCK_SIZE)) + 33'd1;
    diff    = $signed({2'b00, cnt}) - $signed({1'b0, exp_hp});
    match   = (diff <= TOL_S) && (diff >= -TOL_S);
    timeout = !mclk_edge && ({2'b00, cnt} > {exp_hp, 1'b0});
  end

  always_ff @(posedge physical_clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_UNLOCKED;
      good_q  <= '0;
      locked  <= 1'b0;
      lost    <= 1'b0;
    end else begin
      state_q <= state_nxt;
      good_q  <= good_nxt;
      locked  <= locked_nxt;
      lost    <= lost_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    good_nxt  = good_q;
    unique case (state_q)
      ST_UNLOCKED: begin
        if (mclk_edge) begin
          state_nxt = ST_LOCKING;
          good_nxt  = '0;
        end
      end
      ST_LOCKING: begin
        if (mclk_edge && match) begin
          if (good_q == GW'(LOCK_COUNT - 1)) begin
            state_nxt = ST_LOCKED;
            good_nxt  = '0;
          end else begin
            good_nxt = good_q + GW'(1);
          end
        end else if (mclk_edge || timeout) begin
          good_nxt = '0;
        end
      end
      ST_LOCKED: begin
        if ((mclk_edge && !match) || timeout) begin
          state_nxt = ST_LOST;
        end
      end
      ST_LOST: begin
        // the interval ending at this edge started while lost, so it is not judged
        if (mclk_edge) begin
          state_nxt = ST_LOCKING;
          good_nxt  = '0;
        end
      end
      default: begin
        state_nxt = ST_UNLOCKED;
        good_nxt  = '0;
      end
    endcase
  end

  always_comb begin
    locked_nxt = (state_nxt == ST_LOCKED);
    lost_nxt   = lost;
    if (state_nxt == ST_LOST && state_q != ST_LOST) begin
      lost_nxt = 1'b1;
    end else if (state_nxt == ST_LOCKED && state_q != ST_LOCKED) begin
      lost_nxt = 1'b0;
    end
  end

endmodule
